// File: rtl/alu_decode.sv
// alu_decode: decode/issue stage in front of the ALU.
// Decodes RV32I OP, OP-IMM and LUI words into ALU op, register indices,
// immediate and writeback controls. Illegal words are flagged and counted.
// An output register plus one skid register keep in_ready registered.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              input handshake
//   in_instr, in_pc                instruction word and its address
//   out_valid/out_ready            output handshake
//   out_op, out_rs1/rs2/rd         ALU op code and register indices
//   out_imm, out_use_imm           immediate, ALU src_b select
//   out_rd_we, out_illegal, out_pc writeback enable, illegal flag, address
//   illegal_cnt                    saturating count of accepted illegal words
module alu_decode #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [31:0]      in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       out_op,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [4:0]       out_rd,
   output logic [31:0]      out_imm,
   output logic             out_use_imm,
   output logic             out_rd_we,
   output logic             out_illegal,
   output logic [31:0]      out_pc,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;
   localparam int unsigned OP_W  = 5;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;

   localparam logic [OP_W-1:0] ALU_PASS = 5'h0;
   localparam logic [OP_W-1:0] ALU_ADD  = 5'h1;
   localparam logic [OP_W-1:0] ALU_XOR  = 5'h2;
   localparam logic [OP_W-1:0] ALU_OR   = 5'h3;
   localparam logic [OP_W-1:0] ALU_AND  = 5'h4;
   localparam logic [OP_W-1:0] ALU_SUB  = 5'h5;
   localparam logic [OP_W-1:0] ALU_SLTU = 5'h6;
   localparam logic [OP_W-1:0] ALU_SLL  = 5'h7;
   localparam logic [OP_W-1:0] ALU_SRL  = 5'h8;
   localparam logic [OP_W-1:0] ALU_SRA  = 5'h9;
   localparam logic [OP_W-1:0] ALU_SLT  = 5'hA;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  imm;
      logic             use_imm;
      logic             rd_we;
      logic             illegal;
      logic [XLEN-1:0]  pc;
   } entry_t;

   entry_t           dec_c;
   entry_t           out_q, out_d, skid_q, skid_d;
   logic             out_valid_q, out_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept_c;

   logic [6:0]       opcode;
   logic [2:0]       f3;
   logic [6:0]       f7;
   logic [OP_W-1:0]  op_sel;
   logic [XLEN-1:0]  imm_sel;
   logic             legal;
   logic             use_imm_sel;

   assign opcode   = in_instr[6:0];
   assign f3       = in_instr[14:12];
   assign f7       = in_instr[31:25];
   assign accept_c = in_valid & in_ready_q;

   // Instruction decode
   always_comb begin
      legal       = 1'b0;
      op_sel      = ALU_PASS;
      imm_sel     = '0;
      use_imm_sel = 1'b0;
      dec_c       = '0;
      dec_c.rs1   = in_instr[19:15];
      dec_c.rs2   = in_instr[24:20];
      dec_c.rd    = in_instr[11:7];
      dec_c.pc    = in_pc;
      unique case (opcode)
         OPC_OP: begin
            legal = (f7 == F7_BASE);
            unique case (f3)
               3'b000: begin
                  op_sel = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                  legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
               end
               3'b001: op_sel = ALU_SLL;
               3'b010: op_sel = ALU_SLT;
               3'b011: op_sel = ALU_SLTU;
               3'b100: op_sel = ALU_XOR;
               3'b101: begin
                  op_sel = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                  legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
               end
               3'b110: op_sel = ALU_OR;
               3'b111: op_sel = ALU_AND;
            endcase
         end
         OPC_OPIMM: begin
            legal       = 1'b1;
            use_imm_sel = 1'b1;
            imm_sel     = {{20{in_instr[31]}}, in_instr[31:20]};
            unique case (f3)
               3'b000: op_sel = ALU_ADD;
               3'b001: begin
                  op_sel = ALU_SLL;
                  legal  = (f7 == F7_BASE);
               end
               3'b010: op_sel = ALU_SLT;
               3'b011: op_sel = ALU_SLTU;
               3'b100: op_sel = ALU_XOR;
               3'b101: begin
                  op_sel = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                  legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
               end
               3'b110: op_sel = ALU_OR;
               3'b111: op_sel = ALU_AND;
            endcase
         end
         OPC_LUI: begin
            legal       = 1'b1;
            op_sel      = ALU_ADD;
            use_imm_sel = 1'b1;
            imm_sel     = {in_instr[31:12], 12'b0};
            dec_c.rs1   = '0;
         end
         default: legal = 1'b0;
      endcase
      // Illegal words keep raw register fields but no op, immediate or writeback
      dec_c.op      = legal ? op_sel : ALU_PASS;
      dec_c.imm     = legal ? imm_sel : '0;
      dec_c.use_imm = legal & use_imm_sel;
      dec_c.rd_we   = legal;
      dec_c.illegal = ~legal;
   end

   // Output/skid next state; skid is only ever filled while the output stalls
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      cnt_d        = cnt_q;
      if (!out_valid_q || out_ready) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept_c) begin
            out_d       = dec_c;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept_c) begin
         skid_d       = dec_c;
         skid_valid_d = 1'b1;
      end
      if (accept_c && dec_c.illegal && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      in_ready_d = ~skid_valid_d;
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         cnt_q        <= '0;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
         cnt_q        <= cnt_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_op      = out_q.op;
   assign out_rs1     = out_q.rs1;
   assign out_rs2     = out_q.rs2;
   assign out_rd      = out_q.rd;
   assign out_imm     = out_q.imm;
   assign out_use_imm = out_q.use_imm;
   assign out_rd_we   = out_q.rd_we;
   assign out_illegal = out_q.illegal;
   assign out_pc      = out_q.pc;
   assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_decode.sv
// Testbench for alu_decode: directed decode table, stall/skid sequence,
// randomized traffic against a queue-based reference model, reset mid-transfer.
module tb_alu_decode;

   localparam int unsigned CNT_W = 3;

   typedef struct packed {
      logic [4:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        use_imm;
      logic        rd_we;
      logic        illegal;
      logic [31:0] pc;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      exp_t        e;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [31:0]      in_pc;
   logic             out_valid;
   logic             out_ready;
   logic [4:0]       out_op, out_rs1, out_rs2, out_rd;
   logic [31:0]      out_imm;
   logic             out_use_imm, out_rd_we, out_illegal;
   logic [31:0]      out_pc;
   logic [CNT_W-1:0] illegal_cnt;

   int   n_chk  = 0;
   int   n_fail = 0;
   int   n_pop  = 0;
   exp_t q[$];
   int   m_cnt  = 0;

   alu_decode #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op(out_op), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_imm(out_imm), .out_use_imm(out_use_imm), .out_rd_we(out_rd_we),
      .out_illegal(out_illegal), .out_pc(out_pc), .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_entry(input string tag, input exp_t e);
      chk({tag, ".op"},      32'(out_op),      32'(e.op));
      chk({tag, ".rs1"},     32'(out_rs1),     32'(e.rs1));
      chk({tag, ".rs2"},     32'(out_rs2),     32'(e.rs2));
      chk({tag, ".rd"},      32'(out_rd),      32'(e.rd));
      chk({tag, ".imm"},     out_imm,          e.imm);
      chk({tag, ".use_imm"}, 32'(out_use_imm), 32'(e.use_imm));
      chk({tag, ".rd_we"},   32'(out_rd_we),   32'(e.rd_we));
      chk({tag, ".illegal"}, 32'(out_illegal), 32'(e.illegal));
      chk({tag, ".pc"},      out_pc,           e.pc);
   endtask

   // Reference decode written from the instruction-set rules
   function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
      exp_t       e;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       imm_form;
      int         op;
      f3 = w[14:12];
      f7 = w[31:25];
      op = -1;
      e = '0;
      e.rs1 = w[19:15];
      e.rs2 = w[24:20];
      e.rd  = w[11:7];
      e.pc  = pc;
      if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
         imm_form = (w[5] == 1'b0);
         case (f3)
            3'd0: op = 1;
            3'd1: op = 7;
            3'd2: op = 10;
            3'd3: op = 6;
            3'd4: op = 2;
            3'd5: op = 8;
            3'd6: op = 3;
            default: op = 4;
         endcase
         if (f7 == 7'h20 && f3 == 3'd5) op = 9;
         else if (f7 == 7'h20 && f3 == 3'd0 && !imm_form) op = 5;
         else if (f7 != 7'h00 && (!imm_form || f3 == 3'd1 || f3 == 3'd5)) op = -1;
         if (op >= 0) begin
            e.op      = 5'(op);
            e.use_imm = imm_form;
            e.imm     = imm_form ? {{20{w[31]}}, w[31:20]} : 32'h0;
            e.rd_we   = 1'b1;
         end
      end else if (w[6:0] == 7'h37) begin
         op        = 1;
         e.op      = 5'd1;
         e.rs1     = 5'd0;
         e.imm     = {w[31:12], 12'h000};
         e.use_imm = 1'b1;
         e.rd_we   = 1'b1;
      end
      if (op < 0) e.illegal = 1'b1;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int unsigned k;
      w = $urandom;
      k = $urandom_range(0, 4);
      case (k)
         0, 1: begin
            w[6:0] = (k == 0) ? 7'h33 : 7'h13;
            case ($urandom_range(0, 3))
               0, 1: w[31:25] = 7'h00;
               2:    w[31:25] = 7'h20;
               default: ;
            endcase
         end
         2: w[6:0] = 7'h37;
         default: ;
      endcase
      return w;
   endfunction

   // One clock: check state against model at negedge, drive, update on posedge
   task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy);
      logic acc, fire;
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
      if (q.size() > 0) chk_entry("head", q[0]);
      in_valid  = iv;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = ordy;
      acc  = iv && (q.size() < 2);
      fire = ordy && (q.size() > 0);
      @(posedge clk);
      if (fire) begin
         void'(q.pop_front());
         n_pop++;
      end
      if (acc) begin
         exp_t e;
         e = ref_decode(ins, pc);
         q.push_back(e);
         if (e.illegal && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
   endtask

   task automatic do_reset();
      exp_t z;
      z = '0;
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.illegal_cnt", 32'(illegal_cnt), 32'd0);
      chk_entry("rst", z);
      rst = 1'b0;
      q.delete();
      m_cnt = 0;
   endtask

   vec_t vecs[9];
   int   pop0;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
      //                 op     rs1    rs2    rd     imm            ui    we    ill   pc
      vecs[0] = '{32'h00500093, '{5'h1, 5'd0, 5'd5,  5'd1, 32'h00000005, 1'b1, 1'b1, 1'b0, 32'h100}};
      vecs[1] = '{32'h402081B3, '{5'h5, 5'd1, 5'd2,  5'd3, 32'h00000000, 1'b0, 1'b1, 1'b0, 32'h104}};
      vecs[2] = '{32'h40335293, '{5'h9, 5'd6, 5'd3,  5'd5, 32'h00000403, 1'b1, 1'b1, 1'b0, 32'h108}};
      vecs[3] = '{32'h123453B7, '{5'h1, 5'd0, 5'd3,  5'd7, 32'h12345000, 1'b1, 1'b1, 1'b0, 32'h10C}};
      vecs[4] = '{32'h0000007F, '{5'h0, 5'd0, 5'd0,  5'd0, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'h110}};
      vecs[5] = '{32'h02109093, '{5'h0, 5'd1, 5'd1,  5'd1, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'h114}};
      vecs[6] = '{32'h0020C1B3, '{5'h2, 5'd1, 5'd2,  5'd3, 32'h00000000, 1'b0, 1'b1, 1'b0, 32'h118}};
      vecs[7] = '{32'hFFF00093, '{5'h1, 5'd0, 5'd31, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h11C}};
      vecs[8] = '{32'h402091B3, '{5'h0, 5'd1, 5'd2,  5'd3, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'h120}};

      do_reset();

      // Directed decode table, one instruction at a time, output always ready
      for (int i = 0; i < 9; i++) begin
         cycle(1'b1, vecs[i].instr, vecs[i].e.pc, 1'b1);
         #1;
         chk("vec.out_valid", 32'(out_valid), 32'd1);
         chk_entry($sformatf("vec%0d", i), vecs[i].e);
         cycle(1'b0, 32'h0, 32'h0, 1'b1);
      end
      @(negedge clk);
      chk("vec.illegal_cnt", 32'(illegal_cnt), 32'd3);

      // Stall: two accepted, in_ready drops, then drain in order
      pop0 = n_pop;
      cycle(1'b1, 32'h00100113, 32'h200, 1'b0);
      cycle(1'b1, 32'h0000007F, 32'h204, 1'b0);
      #1;
      chk("stall.in_ready", 32'(in_ready), 32'd0);
      chk("stall.out_pc", out_pc, 32'h200);
      cycle(1'b1, 32'h00300193, 32'h208, 1'b0);
      cycle(1'b1, 32'h00300193, 32'h208, 1'b0);
      #1;
      chk("stall.hold_pc", out_pc, 32'h200);
      cycle(1'b1, 32'h00300193, 32'h208, 1'b1);
      cycle(1'b1, 32'h00300193, 32'h208, 1'b1);
      cycle(1'b1, 32'h00400213, 32'h20C, 1'b1);
      cycle(1'b0, 32'h0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 32'h0, 1'b1);
      chk("stall.delivered", 32'(n_pop - pop0), 32'd4);

      // Randomized traffic; counter width is small so saturation is reached
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom % 4) != 0, rand_instr(), $urandom, ($urandom % 3) != 0);
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1);
      chk("rand.saturated", 32'(illegal_cnt), 32'((1 << CNT_W) - 1));

      // Reset with both entries occupied
      cycle(1'b1, 32'h0000007F, 32'h300, 1'b0);
      cycle(1'b1, 32'h00500093, 32'h304, 1'b0);
      #1;
      chk("full.in_ready", 32'(in_ready), 32'd0);
      do_reset();
      cycle(1'b0, 32'h0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 32'h0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
